riscv_opsel_pipe: RTL and testbench

Registered, parametrised ALU operand-select stage for the pipelined RISC-V core. It sits between decode/register-read and execute. It chooses operand A (rs1/pc/zero) and operand B (rs2/imm/4), and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB write ports. Results are presented through a one-deep valid/ready pipeline register with flush.

---
 rtl/riscv_opsel_pkg.sv | 28 ++
 rtl/riscv_opsel_pipe_if.sv | 47 ++++
 rtl/riscv_fwd_unit.sv | 35 +++
 rtl/riscv_opsel_pipe.sv | 112 +++++++++++
 tb/tb_riscv_opsel_pipe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_opsel_pkg.sv
// Shared encodings for the ALU operand-select stage.
package riscv_opsel_pkg;

   // Operand A select; 2'b11 is reserved and drives zero.
   typedef enum logic [1:0] {
      ASEL_RS1  = 2'b00,
      ASEL_PC   = 2'b01,
      ASEL_ZERO = 2'b10
   } asel_e;

   // Operand B select; 2'b11 is reserved and drives zero.
   typedef enum logic [1:0] {
      BSEL_RS2  = 2'b00,
      BSEL_IMM  = 2'b01,
      BSEL_FOUR = 2'b10
   } bsel_e;

   // Source that supplied a register operand.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_e;

   // Instruction size in bytes, used as the link/next-pc increment.
   localparam int unsigned OPB_FOUR = 4;

endpackage

// File: rtl/riscv_opsel_pipe_if.sv
// Request/response bundle between decode, the operand-select stage and execute.
interface riscv_opsel_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 15,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [PC_WIDTH-1:0]   pc;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic [ADDR_WIDTH-1:0] rs1_addr;
   logic [ADDR_WIDTH-1:0] rs2_addr;
   logic [DATA_WIDTH-1:0] imm;
   logic [1:0]            asel;
   logic [1:0]            bsel;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  wb_wr_en;
   logic [ADDR_WIDTH-1:0] wb_rd_addr;
   logic [DATA_WIDTH-1:0] wb_rd_data;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] opa;
   logic [DATA_WIDTH-1:0] opb;
   logic [DATA_WIDTH-1:0] store_data;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;

   // Decode/execute side: issues requests and consumes operands.
   modport master (
      output in_valid, pc, rs1_data, rs2_data, rs1_addr, rs2_addr, imm, asel, bsel,
             mem_wr_en, mem_rd_addr, mem_rd_data, wb_wr_en, wb_rd_addr, wb_rd_data,
             flush, out_ready,
      input  in_ready, out_valid, opa, opb, store_data, fwd_a, fwd_b
   );

   // The operand-select stage itself.
   modport slave (
      input  in_valid, pc, rs1_data, rs2_data, rs1_addr, rs2_addr, imm, asel, bsel,
             mem_wr_en, mem_rd_addr, mem_rd_data, wb_wr_en, wb_rd_addr, wb_rd_data,
             flush, out_ready,
      output in_ready, out_valid, opa, opb, store_data, fwd_a, fwd_b
   );
endinterface

// File: rtl/riscv_fwd_unit.sv
// RAW-hazard resolution for one source register: MEM beats WB, x0 never forwarded.
module riscv_fwd_unit
   import riscv_opsel_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [DATA_WIDTH-1:0] rf_data,
   input  logic                  mem_wr_en,
   input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   input  logic                  wb_wr_en,
   input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
   input  logic [DATA_WIDTH-1:0] wb_rd_data,
   output logic [DATA_WIDTH-1:0] fwd_data,
   output logic [1:0]            fwd_src
);

   // Priority select: x0 guard, then the younger MEM result, then WB, else regfile.
   always_comb begin
      fwd_data = rf_data;
      fwd_src  = FWD_RF;
      if (src_addr != '0) begin
         if (mem_wr_en && (mem_rd_addr == src_addr)) begin
            fwd_data = mem_rd_data;
            fwd_src  = FWD_MEM;
         end else if (wb_wr_en && (wb_rd_addr == src_addr)) begin
            fwd_data = wb_rd_data;
            fwd_src  = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/riscv_opsel_pipe.sv
// ALU operand-select stage: forwarding, operand muxes and a one-deep valid/ready register.
module riscv_opsel_pipe
   import riscv_opsel_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 15,
   parameter int ADDR_WIDTH = 5
) (
   input logic               clk,
   input logic               rst,
   riscv_opsel_pipe_if.slave bus
);

   logic [ADDR_WIDTH-1:0] src_addr [2];
   logic [DATA_WIDTH-1:0] src_rf   [2];
   logic [DATA_WIDTH-1:0] src_data [2];
   logic [1:0]            src_code [2];

   logic                  out_valid_reg;
   logic [DATA_WIDTH-1:0] opa_reg, opa_next;
   logic [DATA_WIDTH-1:0] opb_reg, opb_next;
   logic [DATA_WIDTH-1:0] store_data_reg;
   logic [1:0]            fwd_a_reg, fwd_a_next;
   logic [1:0]            fwd_b_reg;
   logic [DATA_WIDTH-1:0] pc_ext;
   logic                  in_ready_int;
   logic                  load;

   assign src_addr[0] = bus.rs1_addr;
   assign src_addr[1] = bus.rs2_addr;
   assign src_rf[0]   = bus.rs1_data;
   assign src_rf[1]   = bus.rs2_data;

   // One forwarding unit per source register (index 0 = rs1, 1 = rs2).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         riscv_fwd_unit #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_fwd (
            .src_addr    (src_addr[gi]),
            .rf_data     (src_rf[gi]),
            .mem_wr_en   (bus.mem_wr_en),
            .mem_rd_addr (bus.mem_rd_addr),
            .mem_rd_data (bus.mem_rd_data),
            .wb_wr_en    (bus.wb_wr_en),
            .wb_rd_addr  (bus.wb_rd_addr),
            .wb_rd_data  (bus.wb_rd_data),
            .fwd_data    (src_data[gi]),
            .fwd_src     (src_code[gi])
         );
      end
   endgenerate

   // Operand muxes; reserved selects fall to zero, fwd_a only reports when rs1 is used.
   always_comb begin
      pc_ext                 = '0;
      pc_ext[PC_WIDTH-1:0]   = bus.pc;
      opa_next               = '0;
      opb_next               = '0;
      fwd_a_next             = FWD_RF;
      case (bus.asel)
         ASEL_RS1: begin
            opa_next   = src_data[0];
            fwd_a_next = src_code[0];
         end
         ASEL_PC:  opa_next = pc_ext;
         default:  opa_next = '0;
      endcase
      case (bus.bsel)
         BSEL_RS2:  opb_next = src_data[1];
         BSEL_IMM:  opb_next = bus.imm;
         BSEL_FOUR: opb_next = DATA_WIDTH'(OPB_FOUR);
         default:   opb_next = '0;
      endcase
   end

   assign in_ready_int = !out_valid_reg || bus.out_ready;
   assign load         = bus.in_valid && in_ready_int;

   // Pipeline register: reset beats flush, flush beats load; hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         opa_reg        <= '0;
         opb_reg        <= '0;
         store_data_reg <= '0;
         fwd_a_reg      <= FWD_RF;
         fwd_b_reg      <= FWD_RF;
      end else if (bus.flush) begin
         out_valid_reg  <= 1'b0;
      end else if (load) begin
         out_valid_reg  <= 1'b1;
         opa_reg        <= opa_next;
         opb_reg        <= opb_next;
         store_data_reg <= src_data[1];
         fwd_a_reg      <= fwd_a_next;
         fwd_b_reg      <= src_code[1];
      end else if (bus.out_ready) begin
         out_valid_reg  <= 1'b0;
      end
   end

   assign bus.in_ready   = in_ready_int;
   assign bus.out_valid  = out_valid_reg;
   assign bus.opa        = opa_reg;
   assign bus.opb        = opb_reg;
   assign bus.store_data = store_data_reg;
   assign bus.fwd_a      = fwd_a_reg;
   assign bus.fwd_b      = fwd_b_reg;

endmodule

// File: tb/tb_riscv_opsel_pipe.sv
// Scoreboard bench for riscv_opsel_pipe: directed vectors with hand-computed results.
module tb_riscv_opsel_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;

   always #5 clk = ~clk;

   riscv_opsel_pipe_if #(.DATA_WIDTH(32), .PC_WIDTH(15), .ADDR_WIDTH(5)) bus ();

   riscv_opsel_pipe #(.DATA_WIDTH(32), .PC_WIDTH(15), .ADDR_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  asel;
      logic [1:0]  bsel;
      logic [14:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1_addr;
      logic [31:0] rs1_data;
      logic [4:0]  rs2_addr;
      logic [31:0] rs2_data;
      logic        mem_wr_en;
      logic [4:0]  mem_rd_addr;
      logic [31:0] mem_rd_data;
      logic        wb_wr_en;
      logic [4:0]  wb_rd_addr;
      logic [31:0] wb_rd_data;
      logic [31:0] exp_opa;
      logic [31:0] exp_opb;
      logic [31:0] exp_store;
      logic [1:0]  exp_fwd_a;
      logic [1:0]  exp_fwd_b;
   } vec_t;

   vec_t q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t blank();
      vec_t v;
      v.asel = 2'b00; v.bsel = 2'b00; v.pc = '0; v.imm = '0;
      v.rs1_addr = '0; v.rs1_data = '0; v.rs2_addr = '0; v.rs2_data = '0;
      v.mem_wr_en = 1'b0; v.mem_rd_addr = '0; v.mem_rd_data = '0;
      v.wb_wr_en = 1'b0; v.wb_rd_addr = '0; v.wb_rd_data = '0;
      v.exp_opa = '0; v.exp_opb = '0; v.exp_store = '0; v.exp_fwd_a = 2'b00; v.exp_fwd_b = 2'b00;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      bus.asel = v.asel; bus.bsel = v.bsel; bus.pc = v.pc; bus.imm = v.imm;
      bus.rs1_addr = v.rs1_addr; bus.rs1_data = v.rs1_data;
      bus.rs2_addr = v.rs2_addr; bus.rs2_data = v.rs2_data;
      bus.mem_wr_en = v.mem_wr_en; bus.mem_rd_addr = v.mem_rd_addr; bus.mem_rd_data = v.mem_rd_data;
      bus.wb_wr_en = v.wb_wr_en; bus.wb_rd_addr = v.wb_rd_addr; bus.wb_rd_data = v.wb_rd_data;
   endtask

   // Present a request until accepted; the expected result is queued at the accept.
   task automatic issue(input vec_t v, input bit push);
      bit done = 1'b0;
      apply(v);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            if (push) q.push_back(v);
            done = 1'b1;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout actual=in_ready_low required=accept");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && q.size() != 0; i++) tick();
      check("drain_queue_empty", 32'(q.size()), 32'd0);
   endtask

   // Monitor: every transfer out is compared against the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=opa_%h required=no_output", bus.opa);
         end else begin
            vec_t e;
            e = q.pop_front();
            $display("txn %0d opa=%h opb=%h store=%h fwd_a=%b fwd_b=%b", txn,
                     bus.opa, bus.opb, bus.store_data, bus.fwd_a, bus.fwd_b);
            check("opa", bus.opa, e.exp_opa);
            check("opb", bus.opb, e.exp_opb);
            check("store_data", bus.store_data, e.exp_store);
            check("fwd_a", 32'(bus.fwd_a), 32'(e.exp_fwd_a));
            check("fwd_b", 32'(bus.fwd_b), 32'(e.exp_fwd_b));
            txn++;
         end
      end
   end

   initial begin
      vec_t v;
      vec_t b1, b2, b3;
      apply(blank());
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_opa", bus.opa, 32'd0);
      rst = 1'b0;
      tick();

      // pc / immediate select; store_data still carries rs2
      v = blank();
      v.asel = 2'b01; v.pc = 15'h1234; v.bsel = 2'b01; v.imm = 32'hFFFF_FFF0;
      v.rs2_addr = 5'd3; v.rs2_data = 32'h0000_3333;
      v.exp_opa = 32'h0000_1234; v.exp_opb = 32'hFFFF_FFF0; v.exp_store = 32'h0000_3333;
      issue(v, 1'b1);

      // zero / four; rs1 would forward but asel ignores it so fwd_a = 00
      v = blank();
      v.asel = 2'b10; v.bsel = 2'b10; v.rs1_addr = 5'd5;
      v.mem_wr_en = 1'b1; v.mem_rd_addr = 5'd5; v.mem_rd_data = 32'hAAAA_AAAA;
      v.exp_opa = 32'd0; v.exp_opb = 32'd4;
      issue(v, 1'b1);

      // MEM beats WB
      v = blank();
      v.rs1_addr = 5'd5; v.rs1_data = 32'h1111_1111;
      v.rs2_addr = 5'd6; v.rs2_data = 32'h6666_6666;
      v.mem_wr_en = 1'b1; v.mem_rd_addr = 5'd5; v.mem_rd_data = 32'hAAAA_AAAA;
      v.wb_wr_en  = 1'b1; v.wb_rd_addr  = 5'd5; v.wb_rd_data  = 32'hBBBB_BBBB;
      v.exp_opa = 32'hAAAA_AAAA; v.exp_fwd_a = 2'b01;
      v.exp_opb = 32'h6666_6666; v.exp_store = 32'h6666_6666;
      issue(v, 1'b1);

      // WB when MEM write disabled
      v.mem_wr_en = 1'b0;
      v.exp_opa = 32'hBBBB_BBBB; v.exp_fwd_a = 2'b10;
      issue(v, 1'b1);

      // x0 is never forwarded
      v = blank();
      v.mem_wr_en = 1'b1; v.mem_rd_addr = 5'd0; v.mem_rd_data = 32'hDEAD_BEEF;
      v.wb_wr_en  = 1'b1; v.wb_rd_addr  = 5'd0; v.wb_rd_data  = 32'hFEED_FACE;
      issue(v, 1'b1);

      // rs2 from WB, reserved asel drives zero
      v = blank();
      v.asel = 2'b11; v.bsel = 2'b01; v.imm = 32'h0000_0010;
      v.rs1_addr = 5'd7; v.rs1_data = 32'h7777_7777;
      v.rs2_addr = 5'd7; v.rs2_data = 32'h0BAD_0BAD;
      v.mem_wr_en = 1'b1; v.mem_rd_addr = 5'd8; v.mem_rd_data = 32'h8888_8888;
      v.wb_wr_en  = 1'b1; v.wb_rd_addr  = 5'd7; v.wb_rd_data  = 32'hCAFE_F00D;
      v.exp_opa = 32'd0; v.exp_opb = 32'h0000_0010;
      v.exp_store = 32'hCAFE_F00D; v.exp_fwd_b = 2'b10;
      issue(v, 1'b1);

      // both sources from MEM, reserved bsel drives zero
      v = blank();
      v.asel = 2'b00; v.bsel = 2'b11;
      v.rs1_addr = 5'd9; v.rs2_addr = 5'd9;
      v.mem_wr_en = 1'b1; v.mem_rd_addr = 5'd9; v.mem_rd_data = 32'h1234_5678;
      v.wb_wr_en  = 1'b1; v.wb_rd_addr  = 5'd9; v.wb_rd_data  = 32'h9999_9999;
      v.exp_opa = 32'h1234_5678; v.exp_fwd_a = 2'b01;
      v.exp_opb = 32'd0; v.exp_store = 32'h1234_5678; v.exp_fwd_b = 2'b01;
      issue(v, 1'b1);
      drain();

      // Backpressure: three back-to-back requests, consumer stalls two cycles after the first
      b1 = blank();
      b1.asel = 2'b00; b1.bsel = 2'b01; b1.imm = 32'd100; b1.rs1_addr = 5'd4;
      b1.mem_wr_en = 1'b1; b1.mem_rd_addr = 5'd4; b1.mem_rd_data = 32'h4444_4444;
      b1.exp_opa = 32'h4444_4444; b1.exp_fwd_a = 2'b01; b1.exp_opb = 32'd100;
      b2 = blank();
      b2.asel = 2'b00; b2.bsel = 2'b01; b2.imm = 32'd200; b2.rs1_addr = 5'd4;
      b2.mem_wr_en = 1'b1; b2.mem_rd_addr = 5'd4; b2.mem_rd_data = 32'h9999_0000;
      b2.exp_opa = 32'h9999_0000; b2.exp_fwd_a = 2'b01; b2.exp_opb = 32'd200;
      b3 = blank();
      b3.asel = 2'b01; b3.pc = 15'h0003; b3.bsel = 2'b01; b3.imm = 32'd300;
      b3.exp_opa = 32'h0000_0003; b3.exp_opb = 32'd300;
      issue(b1, 1'b1);
      bus.out_ready = 1'b0;
      fork
         begin
            issue(b2, 1'b1);
            issue(b3, 1'b1);
         end
         begin
            for (int i = 0; i < 2; i++) begin
               @(negedge clk);
               check("stall_in_ready", 32'(bus.in_ready), 32'd0);
               check("stall_out_valid", 32'(bus.out_valid), 32'd1);
               check("stall_opa_held", bus.opa, 32'h4444_4444);
               check("stall_opb_held", bus.opb, 32'd100);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      tick();

      // Flush: held result and incoming request are both discarded
      bus.out_ready = 1'b0;
      v = blank();
      v.asel = 2'b01; v.pc = 15'h0F0F;
      issue(v, 1'b0);
      check("flush_pre_out_valid", 32'(bus.out_valid), 32'd1);
      v.pc = 15'h0A0A;
      apply(v);
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("flush_stays_empty", 32'(bus.out_valid), 32'd0);

      // Reset while stalled on a held result
      bus.out_ready = 1'b0;
      v = blank();
      v.asel = 2'b01; v.pc = 15'h7FFF; v.bsel = 2'b10;
      v.rs2_addr = 5'd2; v.rs2_data = 32'h2222_2222;
      v.wb_wr_en = 1'b1; v.wb_rd_addr = 5'd2; v.wb_rd_data = 32'h5555_5555;
      issue(v, 1'b0);
      tick();
      check("rst_pre_out_valid", 32'(bus.out_valid), 32'd1);
      check("rst_pre_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_opa", bus.opa, 32'd0);
      check("rst_opb", bus.opb, 32'd0);
      check("rst_store_data", bus.store_data, 32'd0);
      check("rst_fwd_a", 32'(bus.fwd_a), 32'd0);
      check("rst_fwd_b", 32'(bus.fwd_b), 32'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();

      check("total_transactions", 32'(txn), 32'd10);
      check("final_queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
